// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-aligned data update
module seg_scan_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int SCAN_FREQ    = 1000,
  parameter int DIGITS       = 6,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [3:0]            bin_data,
  input  logic [6:0]            seg_data_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     seg_sel,
  output logic                  frame_done
);

  localparam int DIV   = CLK_FREQ / SCAN_FREQ;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int SEL_W = $clog2(4 * DIGITS);

  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*DIGITS-1:0]   pend_data;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_full;
  logic [4*DIGITS-1:0]   shadow_data;
  logic [DIGITS-1:0]     shadow_dp;
  logic [SEL_W-1:0]      bin_base;
  logic                  accept;
  logic                  frame_end;
  logic                  shadow_load;

  assign data_ready = ~pend_full;
  assign accept     = data_valid & ~pend_full;
  assign frame_end  = (state == DRIVE) && (cnt == SLOT_END) && (idx == LAST_IDX);
  // Shadow only changes at scan start or a frame boundary, never mid-frame.
  assign shadow_load = pend_full && enable && ((state == IDLE) || frame_end);

  assign bin_base = SEL_W'({idx, 2'b00});
  assign bin_data = shadow_data[bin_base +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_full   <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      seg_out     <= '0;
      seg_sel     <= '1;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pend_full <= 1'b1;
      end else if (shadow_load) begin
        pend_full <= 1'b0;
      end

      if (shadow_load) begin
        shadow_data <= pend_data;
        shadow_dp   <= pend_dp;
      end

      if (!enable) begin
        state   <= IDLE;
        cnt     <= '0;
        idx     <= '0;
        seg_sel <= '1;
        seg_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_END) begin
              state   <= DRIVE;
              seg_sel <= ~(DIGITS'(1) << idx);
              seg_out <= {shadow_dp[idx], seg_data_in};
            end
          end
          DRIVE: begin
            if (cnt == SLOT_END) begin
              state      <= BLANK;
              cnt        <= '0;
              idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
              seg_sel    <= '1;
              seg_out    <= '0;
              frame_done <= (idx == LAST_IDX);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  bin_data;
  logic [6:0]  seg_data_in;
  logic [7:0]  seg_out;
  logic [3:0]  seg_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .CLK_FREQ(1000),
    .SCAN_FREQ(100),
    .DIGITS(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .data_in(data_in),
    .dp_in(dp_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .bin_data(bin_data),
    .seg_data_in(seg_data_in),
    .seg_out(seg_out),
    .seg_sel(seg_sel),
    .frame_done(frame_done)
  );

  // External BCD decoder, segments {g..a}, codes 10-15 blank.
  always_comb begin
    seg_data_in = 7'h00;
    case (bin_data)
      4'd0: seg_data_in = 7'h3F;
      4'd1: seg_data_in = 7'h06;
      4'd2: seg_data_in = 7'h5B;
      4'd3: seg_data_in = 7'h4F;
      4'd4: seg_data_in = 7'h66;
      4'd5: seg_data_in = 7'h6D;
      4'd6: seg_data_in = 7'h7D;
      4'd7: seg_data_in = 7'h07;
      4'd8: seg_data_in = 7'h7F;
      4'd9: seg_data_in = 7'h6F;
      default: seg_data_in = 7'h00;
    endcase
  end

  // k counts sampled cycles from the first BLANK cycle of a frame; slot = 10 cycles, 2 dark.
  function automatic logic [3:0] exp_sel(int k);
    int c = k % 10;
    int s = (k / 10) % 4;
    if (c < 2) return 4'b1111;
    return ~(4'b0001 << s);
  endfunction

  function automatic logic [7:0] exp_seg(int k, logic [31:0] segs);
    int c = k % 10;
    int s = (k / 10) % 4;
    if (c < 2) return 8'h00;
    return segs[8*s +: 8];
  endfunction

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; data_valid = 1'b0; data_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seg_sel !== 4'b1111 || seg_out !== 8'h00 || frame_done !== 1'b0 ||
        data_ready !== 1'b1 || bin_data !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_hold sel=%b seg=%h fd=%b rdy=%b bin=%h want 1111 00 0 1 0",
               seg_sel, seg_out, frame_done, data_ready, bin_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg_sel !== 4'b1111 || seg_out !== 8'h00 || frame_done !== 1'b0 ||
          data_ready !== 1'b1 || bin_data !== 4'h0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d sel=%b seg=%h fd=%b rdy=%b bin=%h want 1111 00 0 1 0",
                 i, seg_sel, seg_out, frame_done, data_ready, bin_data);
      end
    end
  endtask

  task automatic test_scan;
    logic [15:0] word;
    logic [31:0] segs;
    word = 16'h1234;
    segs = 32'h06DB4F66;
    @(negedge clk);
    data_in = word; dp_in = 4'b0100; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    n_cmp++;
    if (data_ready !== 1'b0) begin
      n_bad++; $display("FAIL accept_idle got rdy=%b want 0", data_ready);
    end
    n_cmp++;
    if (seg_sel !== 4'b1111 || seg_out !== 8'h00) begin
      n_bad++; $display("FAIL idle_dark got sel=%b seg=%h want 1111 00", seg_sel, seg_out);
    end
    enable = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      n_cmp++;
      if (seg_sel !== exp_sel(k)) begin
        n_bad++; $display("FAIL scan_sel k=%0d got %b want %b", k, seg_sel, exp_sel(k));
      end
      n_cmp++;
      if (seg_out !== exp_seg(k, segs)) begin
        n_bad++; $display("FAIL scan_seg k=%0d got %h want %h", k, seg_out, exp_seg(k, segs));
      end
      n_cmp++;
      if (frame_done !== (k == 40)) begin
        n_bad++; $display("FAIL scan_fd k=%0d got %b want %b", k, frame_done, k == 40);
      end
      if (k % 10 == 5) begin
        n_cmp++;
        if (bin_data !== word[4*((k/10)%4) +: 4]) begin
          n_bad++; $display("FAIL scan_bin k=%0d got %h want %h", k, bin_data, word[4*((k/10)%4) +: 4]);
        end
      end
      if (k == 0) begin
        n_cmp++;
        if (data_ready !== 1'b1) begin
          n_bad++; $display("FAIL load_on_enable got rdy=%b want 1", data_ready);
        end
      end
    end
  endtask

  task automatic test_pending;
    logic [31:0] segs;
    for (int k = 80; k < 160; k++) begin
      @(negedge clk);
      segs = (k < 120) ? 32'h06DB4F66 : 32'h6D7D07FF;
      n_cmp++;
      if (seg_sel !== exp_sel(k)) begin
        n_bad++; $display("FAIL pend_sel k=%0d got %b want %b", k, seg_sel, exp_sel(k));
      end
      n_cmp++;
      if (seg_out !== exp_seg(k, segs)) begin
        n_bad++; $display("FAIL pend_seg k=%0d got %h want %h", k, seg_out, exp_seg(k, segs));
      end
      n_cmp++;
      if (frame_done !== (k % 40 == 0)) begin
        n_bad++; $display("FAIL pend_fd k=%0d got %b want %b", k, frame_done, k % 40 == 0);
      end
      if (k == 85) begin
        data_in = 16'h5678; dp_in = 4'b0001; data_valid = 1'b1;
      end
      if (k == 86) begin
        n_cmp++;
        if (data_ready !== 1'b0) begin
          n_bad++; $display("FAIL pend_full got rdy=%b want 0", data_ready);
        end
        data_in = 16'h9999; dp_in = 4'b1111;
      end
      if (k == 110) begin
        n_cmp++;
        if (data_ready !== 1'b0) begin
          n_bad++; $display("FAIL pend_stall got rdy=%b want 0", data_ready);
        end
      end
      if (k == 119) data_valid = 1'b0;
      if (k == 120) begin
        n_cmp++;
        if (data_ready !== 1'b1) begin
          n_bad++; $display("FAIL ready_at_boundary got rdy=%b want 1", data_ready);
        end
      end
    end
  endtask

  task automatic test_boundary_accept;
    logic [31:0] segs;
    data_in = 16'hA3A1; dp_in = 4'b1000; data_valid = 1'b1;
    for (int k = 160; k < 240; k++) begin
      @(negedge clk);
      segs = (k < 200) ? 32'h6D7D07FF : 32'h804F0006;
      n_cmp++;
      if (seg_sel !== exp_sel(k)) begin
        n_bad++; $display("FAIL bnd_sel k=%0d got %b want %b", k, seg_sel, exp_sel(k));
      end
      n_cmp++;
      if (seg_out !== exp_seg(k, segs)) begin
        n_bad++; $display("FAIL bnd_seg k=%0d got %h want %h", k, seg_out, exp_seg(k, segs));
      end
      n_cmp++;
      if (frame_done !== (k % 40 == 0)) begin
        n_bad++; $display("FAIL bnd_fd k=%0d got %b want %b", k, frame_done, k % 40 == 0);
      end
      if (k == 160) begin
        data_valid = 1'b0;
        n_cmp++;
        if (data_ready !== 1'b0) begin
          n_bad++; $display("FAIL bnd_accept got rdy=%b want 0", data_ready);
        end
      end
      if (k == 200) begin
        n_cmp++;
        if (data_ready !== 1'b1) begin
          n_bad++; $display("FAIL bnd_load got rdy=%b want 1", data_ready);
        end
      end
    end
  endtask

  task automatic test_abort;
    logic [31:0] segs;
    segs = 32'h804F0006;
    for (int k = 240; k <= 265; k++) begin
      @(negedge clk);
      n_cmp++;
      if (seg_sel !== exp_sel(k) || seg_out !== exp_seg(k, segs)) begin
        n_bad++; $display("FAIL pre_abort k=%0d got %b %h want %b %h",
                          k, seg_sel, seg_out, exp_sel(k), exp_seg(k, segs));
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg_sel !== 4'b1111 || seg_out !== 8'h00 || frame_done !== 1'b0) begin
        n_bad++; $display("FAIL abort_dark cyc=%0d got sel=%b seg=%h fd=%b want 1111 00 0",
                          i, seg_sel, seg_out, frame_done);
      end
    end
    enable = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if (seg_sel !== exp_sel(k)) begin
        n_bad++; $display("FAIL restart_sel k=%0d got %b want %b", k, seg_sel, exp_sel(k));
      end
      n_cmp++;
      if (seg_out !== exp_seg(k, segs)) begin
        n_bad++; $display("FAIL restart_seg k=%0d got %h want %h", k, seg_out, exp_seg(k, segs));
      end
      n_cmp++;
      if (frame_done !== (k == 40)) begin
        n_bad++; $display("FAIL restart_fd k=%0d got %b want %b", k, frame_done, k == 40);
      end
    end
  endtask

  task automatic test_async_reset;
    data_in = 16'h1111; dp_in = 4'b0000; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    n_cmp++;
    if (data_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_pre_pend got rdy=%b want 0", data_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (seg_out !== 8'h06 || seg_sel !== 4'b1110) begin
      n_bad++; $display("FAIL rst_pre_lit got sel=%b seg=%h want 1110 06", seg_sel, seg_out);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (seg_sel !== 4'b1111 || seg_out !== 8'h00 || frame_done !== 1'b0 ||
        data_ready !== 1'b1 || bin_data !== 4'h0) begin
      n_bad++;
      $display("FAIL async_rst sel=%b seg=%h fd=%b rdy=%b bin=%h want 1111 00 0 1 0",
               seg_sel, seg_out, frame_done, data_ready, bin_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seg_out !== 8'h3F || seg_sel !== 4'b1110) begin
      n_bad++; $display("FAIL rst_cleared_pend got sel=%b seg=%h want 1110 3f", seg_sel, seg_out);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pending();
    test_boundary_accept();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
